// File: rtl/calendar_pkg.sv
// Shared calendar definitions for the date-setting controller and the
// calendar datapath: FSM state encoding, edit-field codes, month constants
// and the month-length function.
package calendar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_YEAR,
    ST_SET_MONTH,
    ST_SET_DAY,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_NONE  = 2'd0;
  localparam logic [1:0] FIELD_YEAR  = 2'd1;
  localparam logic [1:0] FIELD_MONTH = 2'd2;
  localparam logic [1:0] FIELD_DAY   = 2'd3;

  localparam logic [3:0] FEB = 4'd2;

  // Leap rule is year%4 only; within 2000..2099 this is exact.
  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                                input logic [1:0] year_lsb2);
    logic [4:0] d;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
      FEB:                     d = (year_lsb2 == 2'd0) ? 5'd29 : 5'd28;
      default:                 d = 5'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/month_length.sv
// Combinational days-in-month lookup.
//   month_w : month 1..12
//   year_w  : two LSBs of the year (leap detection)
//   dim     : number of days in that month
module month_length
  import calendar_pkg::*;
(
  input  logic [3:0] month_w,
  input  logic [1:0] year_w,
  output logic [4:0] dim
);

  assign dim = days_in_month(month_w, year_w);

endmodule

// File: rtl/date_set_ctrl.sv
// Date-setting controller. Button pulses walk the user through year, month
// and day edits on a working copy of the date, which is always kept legal,
// and the result is committed with a one-cycle date_ow strobe.
//   clk, rst          : clock, synchronous active-high reset
//   btn_mode          : enter edit / advance to next field
//   btn_inc, btn_dec  : step current field up / down (wrapping)
//   btn_cancel        : abandon the edit
//   cur_date          : live date {day[4:0], month[3:0], year}
//   date_out, date_ow : committed date and its overwrite strobe
//   edit_active       : high in any SET_* state
//   edit_field        : 0 none, 1 year, 2 month, 3 day
//   blink             : show/blank phase for the edited field
module date_set_ctrl
  import calendar_pkg::*;
#(
  parameter int YEARRES     = 12,
  parameter int YEAR_MIN    = 2000,
  parameter int YEAR_MAX    = 2099,
  parameter int TIMEOUT_CYC = 30000000,
  parameter int BLINK_HALF  = 12500000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_mode,
  input  logic               btn_inc,
  input  logic               btn_dec,
  input  logic               btn_cancel,
  input  logic [YEARRES+8:0] cur_date,
  output logic [YEARRES+8:0] date_out,
  output logic               date_ow,
  output logic               edit_active,
  output logic [1:0]         edit_field,
  output logic               blink
);

  localparam logic [YEARRES-1:0] Y_MIN = YEARRES'(YEAR_MIN);
  localparam logic [YEARRES-1:0] Y_MAX = YEARRES'(YEAR_MAX);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  state_t state, next_state;

  logic [4:0]         day_w;
  logic [3:0]         month_w;
  logic [YEARRES-1:0] year_w;
  logic [4:0]         dim;

  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] blink_cnt;

  logic [4:0]         cd_day;
  logic [3:0]         cd_mon;
  logic [YEARRES-1:0] cd_year;

  logic step_up, step_dn, any_btn, edit_pulse, tmo_hit;
  logic in_edit, next_in_edit;

  logic [4:0]         day_nx;
  logic [3:0]         month_nx;
  logic [YEARRES-1:0] year_nx;

  assign cd_day  = cur_date[YEARRES+8:YEARRES+4];
  assign cd_mon  = cur_date[YEARRES+3:YEARRES];
  assign cd_year = cur_date[YEARRES-1:0];

  // inc and dec together cancel out
  assign step_up    = btn_inc & ~btn_dec;
  assign step_dn    = btn_dec & ~btn_inc;
  assign any_btn    = btn_mode | btn_inc | btn_dec | btn_cancel;
  assign edit_pulse = btn_mode | btn_inc | btn_dec;
  assign tmo_hit    = (tmo_cnt == TMO_LAST);

  assign in_edit      = state inside {ST_SET_YEAR, ST_SET_MONTH, ST_SET_DAY};
  assign next_in_edit = next_state inside {ST_SET_YEAR, ST_SET_MONTH, ST_SET_DAY};

  month_length u_month_length (
    .month_w (month_w),
    .year_w  (year_w[1:0]),
    .dim     (dim)
  );

  // Wrapped next values; decisions by compare so nothing overflows its field.
  always_comb begin
    year_nx = year_w;
    if (step_up)      year_nx = (year_w >= Y_MAX) ? Y_MIN : year_w + YEARRES'(1);
    else if (step_dn) year_nx = (year_w <= Y_MIN) ? Y_MAX : year_w - YEARRES'(1);
  end

  always_comb begin
    month_nx = month_w;
    if (step_up)      month_nx = (month_w >= 4'd12) ? 4'd1 : month_w + 4'd1;
    else if (step_dn) month_nx = (month_w <= 4'd1) ? 4'd12 : month_w - 4'd1;
  end

  always_comb begin
    day_nx = day_w;
    if (step_up)      day_nx = (day_w >= dim) ? 5'd1 : day_w + 5'd1;
    else if (step_dn) day_nx = (day_w <= 5'd1) ? dim : day_w - 5'd1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state: cancel > mode > (timeout when no button this cycle)
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (btn_mode) next_state = ST_SET_YEAR;
      ST_SET_YEAR,
      ST_SET_MONTH,
      ST_SET_DAY: begin
        if (btn_cancel) next_state = ST_IDLE;
        else if (btn_mode) begin
          case (state)
            ST_SET_YEAR:  next_state = ST_SET_MONTH;
            ST_SET_MONTH: next_state = ST_SET_DAY;
            default:      next_state = ST_COMMIT;
          endcase
        end
        else if (!any_btn && tmo_hit) next_state = ST_IDLE;
      end
      ST_COMMIT:    next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    edit_active = in_edit;
    date_ow     = (state == ST_COMMIT);
    case (state)
      ST_SET_YEAR:  edit_field = FIELD_YEAR;
      ST_SET_MONTH: edit_field = FIELD_MONTH;
      ST_SET_DAY:   edit_field = FIELD_DAY;
      default:      edit_field = FIELD_NONE;
    endcase
  end

  // Working date and committed output
  always_ff @(posedge clk) begin
    if (rst) begin
      day_w    <= 5'd1;
      month_w  <= 4'd1;
      year_w   <= Y_MIN;
      date_out <= {5'd1, 4'd1, Y_MIN};
    end else begin
      case (state)
        ST_IDLE: if (btn_mode) begin
          month_w <= (cd_mon == 4'd0 || cd_mon > 4'd12) ? 4'd1 : cd_mon;
          day_w   <= (cd_day == 5'd0 || cd_day > 5'd31) ? 5'd1 : cd_day;
          year_w  <= (cd_year < Y_MIN || cd_year > Y_MAX) ? Y_MIN : cd_year;
        end
        ST_SET_YEAR: if (!btn_cancel && !btn_mode) year_w <= year_nx;
        ST_SET_MONTH: if (!btn_cancel) begin
          // clamp day on the way into SET_DAY; month is final at this edge
          if (btn_mode) day_w <= (day_w > dim) ? dim : day_w;
          else          month_w <= month_nx;
        end
        ST_SET_DAY: if (!btn_cancel) begin
          if (btn_mode) date_out <= {day_w, month_w, year_w};
          else          day_w <= day_nx;
        end
        default: ;
      endcase
    end
  end

  // Idle timeout: restarts on any button or state change
  always_ff @(posedge clk) begin
    if (rst)                                          tmo_cnt <= '0;
    else if (!in_edit || any_btn || next_state != state) tmo_cnt <= '0;
    else                                              tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Field blink: shown immediately after any edit action
  always_ff @(posedge clk) begin
    if (rst || !next_in_edit) begin
      blink     <= 1'b0;
      blink_cnt <= '0;
    end else if (edit_pulse) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

endmodule

// File: tb/tb_date_set_ctrl.sv
module tb_date_set_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_mode, btn_inc, btn_dec, btn_cancel;
  logic [20:0] cur_date;
  logic [20:0] date_out;
  logic        date_ow;
  logic        edit_active;
  logic [1:0]  edit_field;
  logic        blink;

  int checks = 0;
  int failures = 0;
  int n_exp = 0;
  int n_seen = 0;
  logic [20:0] exp_q[$];
  logic prev_ow = 1'b0;

  always #5 clk = ~clk;

  date_set_ctrl #(
    .YEARRES(12), .YEAR_MIN(2000), .YEAR_MAX(2099),
    .TIMEOUT_CYC(20), .BLINK_HALF(4)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_cancel(btn_cancel),
    .cur_date(cur_date), .date_out(date_out), .date_ow(date_ow),
    .edit_active(edit_active), .edit_field(edit_field), .blink(blink)
  );

  function automatic logic [20:0] mk(input int d, input int m, input int y);
    return {d[4:0], m[3:0], y[11:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard side: every strobe must be expected, single-cycle, and carry
  // the date pushed when the committing button was driven.
  always @(negedge clk) begin
    if (!rst && date_ow) begin
      n_seen++;
      chk("ow_width", {31'd0, prev_ow}, 0);
      chk("ow_expected", {31'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) chk("commit_date", {11'd0, date_out}, {11'd0, exp_q.pop_front()});
    end
    prev_ow <= date_ow;
  end

  // Inputs change at posedge+1; task returns at the next posedge+1.
  task automatic press(input logic m, input logic i, input logic d, input logic c);
    btn_mode = m; btn_inc = i; btn_dec = d; btn_cancel = c;
    @(posedge clk); #1;
    btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic commit(input logic [20:0] e);
    exp_q.push_back(e);
    n_exp++;
    press(1, 0, 0, 0);
    chk("ow_latency", {31'd0, date_ow}, 1);
    chk("field_commit", {30'd0, edit_field}, 0);
    chk("blink_commit", {31'd0, blink}, 0);
    idle(1);
    chk("ow_drop", {31'd0, date_ow}, 0);
    chk("hold_date", {11'd0, date_out}, {11'd0, e});
  endtask

  initial begin
    rst = 1; btn_mode = 0; btn_inc = 0; btn_dec = 0; btn_cancel = 0;
    cur_date = mk(1, 1, 2000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ow", {31'd0, date_ow}, 0);
    chk("rst_active", {31'd0, edit_active}, 0);
    chk("rst_field", {30'd0, edit_field}, 0);
    chk("rst_blink", {31'd0, blink}, 0);
    chk("rst_date", {11'd0, date_out}, {11'd0, mk(1, 1, 2000)});
    rst = 0;
    idle(1);

    // IDLE ignores inc/dec/cancel
    press(0, 1, 0, 0); press(0, 0, 1, 1);
    chk("idle_ignore", {31'd0, edit_active}, 0);

    // Full set: 15/06/2023 -> 16/05/2025
    cur_date = mk(15, 6, 2023);
    press(1, 0, 0, 0);
    chk("fs_field1", {30'd0, edit_field}, 1);
    chk("fs_active", {31'd0, edit_active}, 1);
    chk("fs_blink", {31'd0, blink}, 1);
    press(0, 1, 0, 0); press(0, 1, 0, 0);
    press(1, 0, 0, 0);
    chk("fs_field2", {30'd0, edit_field}, 2);
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    chk("fs_field3", {30'd0, edit_field}, 3);
    press(0, 1, 0, 0);
    commit(mk(16, 5, 2025));

    // Leap clamp: 31/03/2024 -> Feb -> 29
    cur_date = mk(31, 3, 2024);
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 0, 1, 0); press(1, 0, 0, 0);
    commit(mk(29, 2, 2024));
    // non-leap: 31/03/2023 -> 28
    cur_date = mk(31, 3, 2023);
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 0, 1, 0); press(1, 0, 0, 0);
    commit(mk(28, 2, 2023));
    // 29/02/2024 + inc -> 1
    cur_date = mk(29, 2, 2024);
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0);
    commit(mk(1, 2, 2024));

    // Wrap: 2099+1 -> 2000, month 1-1 -> 12
    cur_date = mk(1, 1, 2099);
    press(1, 0, 0, 0); press(0, 1, 0, 0); press(1, 0, 0, 0); press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    commit(mk(1, 12, 2000));
    // year 2000-1 -> 2099, day 1 in April - 1 -> 30
    cur_date = mk(1, 4, 2000);
    press(1, 0, 0, 0); press(0, 0, 1, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    commit(mk(30, 4, 2099));

    // Priority: inc+dec no change; mode+inc advances without change
    cur_date = mk(10, 7, 2040);
    press(1, 0, 0, 0);
    press(0, 1, 1, 0);
    chk("pri_incdec_field", {30'd0, edit_field}, 1);
    press(1, 1, 0, 0);
    chk("pri_modeinc_field", {30'd0, edit_field}, 2);
    press(1, 0, 0, 0);
    commit(mk(10, 7, 2040));
    // cancel+mode in SET_DAY -> IDLE, no strobe
    cur_date = mk(3, 3, 2033);
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0); press(0, 1, 0, 0);
    press(1, 0, 0, 1);
    chk("cancel_active", {31'd0, edit_active}, 0);
    chk("cancel_ow", {31'd0, date_ow}, 0);
    idle(2);
    chk("cancel_date", {11'd0, date_out}, {11'd0, mk(10, 7, 2040)});

    // Timeout with blink phases
    cur_date = mk(5, 5, 2050);
    press(1, 0, 0, 0);
    idle(3);
    chk("blink_hold", {31'd0, blink}, 1);
    idle(1);
    chk("blink_off", {31'd0, blink}, 0);
    idle(4);
    chk("blink_on", {31'd0, blink}, 1);
    idle(11);
    chk("tmo_before", {31'd0, edit_active}, 1);
    idle(1);
    chk("tmo_idle", {31'd0, edit_active}, 0);
    chk("tmo_blink", {31'd0, blink}, 0);
    chk("tmo_date", {11'd0, date_out}, {11'd0, mk(10, 7, 2040)});
    // pulse at cycle 19 restarts the count
    press(1, 0, 0, 0);
    idle(18);
    press(0, 1, 0, 0);
    idle(19);
    chk("tmo_restart", {31'd0, edit_active}, 1);
    idle(1);
    chk("tmo_restart_idle", {31'd0, edit_active}, 0);

    // Reset mid-edit
    cur_date = mk(20, 8, 2060);
    press(1, 0, 0, 0); press(1, 0, 0, 0);
    chk("pre_rst_field", {30'd0, edit_field}, 2);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_field", {30'd0, edit_field}, 0);
    chk("mid_rst_blink", {31'd0, blink}, 0);
    chk("mid_rst_date", {11'd0, date_out}, {11'd0, mk(1, 1, 2000)});
    idle(1);

    // Sanitise: month 13, day 0, year out of range
    cur_date = {5'd0, 4'd13, 12'd2045};
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
    commit(mk(1, 1, 2045));
    cur_date = {5'd31, 4'd0, 12'd3000};
    press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
    commit(mk(31, 1, 2000));

    idle(3);
    chk("commit_count", n_seen, n_exp);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
